ahb_master_arbiter: RTL and testbench

- Shares one AHB-Lite slave bus (memory, peripherals) between N masters: the multicycle core's memory port (master 0) and a DMA engine or debug port (master 1+).
- Selects one address-phase owner per cycle and tracks the registered data-phase owner.
- Steers HWDATA, HREADY and HRESP per master, and stalls losing masters through their local hready.
- Sits between the core's controller/datapath memory interface and the AHB decoder/slave mux.

---
 rtl/ahb_pkg.sv | 34 +++
 rtl/arb_pick.sv | 61 ++++++
 rtl/ahb_master_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_ahb_master_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// -----------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite encodings and types for the master arbiter slice.
//   - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
//   - HSIZE codes (BYTE/HALF/WORD)
//   - HRESP codes (OKAY/ERROR)
//   - mst_idx_t: master index type (up to four masters)
// -----------------------------------------------------------------------------
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    // Largest supported master count; the index type is sized for it.
    localparam int MAX_MASTERS = 4;

    typedef logic [1:0] mst_idx_t;

endpackage : ahb_pkg

// File: rtl/arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational picker: chooses one requester from a request vector.
//   Build option ARB_ROUND_ROBIN_EN:
//     undefined -> fixed priority, master 0 highest (rr_ptr_i port absent)
//     defined   -> round-robin, search starts at rr_ptr_i
// Ports:
//   req_i     in   N_MASTERS  request vector, bit m = master m requesting
//   rr_ptr_i  in   2          round-robin search start (round-robin build only)
//   idx_o     out  2          chosen master; 0 when nobody requests
//   any_o     out  1          at least one master requests
// -----------------------------------------------------------------------------
module arb_pick
    import ahb_pkg::*;
#(
    parameter int N_MASTERS = 2
) (
    input  logic [N_MASTERS-1:0] req_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic [1:0]           rr_ptr_i,
`endif
    output logic [1:0]           idx_o,
    output logic                 any_o
);

`ifdef ARB_ROUND_ROBIN_EN
    // Doubling the vector and shifting by the pointer rotates the requests so
    // that bit p corresponds to master (rr_ptr + p) mod N_MASTERS.
    logic [2*N_MASTERS-1:0] dbl;
    logic [2:0]             sum;

    always_comb begin
        dbl   = {req_i, req_i} >> rr_ptr_i;
        sum   = '0;
        idx_o = '0;
        any_o = |req_i;
        for (int p = N_MASTERS - 1; p >= 0; p--) begin
            if (dbl[p]) begin
                sum = {1'b0, rr_ptr_i} + 3'(p);
            end
        end
        if (sum >= 3'(N_MASTERS)) begin
            idx_o = 2'(sum - 3'(N_MASTERS));
        end else begin
            idx_o = sum[1:0];
        end
    end
`else
    always_comb begin
        idx_o = '0;
        any_o = |req_i;
        // Walk from the highest index down so the lowest requester wins.
        for (int m = N_MASTERS - 1; m >= 0; m--) begin
            if (req_i[m]) begin
                idx_o = 2'(m);
            end
        end
    end
`endif

endmodule : arb_pick

// File: rtl/ahb_master_arbiter.sv
// -----------------------------------------------------------------------------
// ahb_master_arbiter
// Shares one AHB-Lite slave bus between N_MASTERS masters (core = master 0,
// DMA/debug = 1+). One address-phase owner is chosen per cycle; the data-phase
// owner is registered and exposed on hmaster/hmaster_vld.
//
// Handshake: a master's transfer is accepted when it drives NONSEQ/SEQ and its
// m_hready is 1 at the rising edge; a master whose m_hready is 0 must hold its
// address-phase signals. The bus side accepts an address phase when hready=1.
//
// Build option ARB_ROUND_ROBIN_EN: round-robin picker with rr_ptr state;
// undefined gives fixed priority (master 0 highest) and no rr_ptr.
//
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   m_haddr/htrans/hwrite/hsize/hwdata   packed per-master inputs
//   m_hready, m_hresp          per-master ready / response
//   m_hrdata                   read data broadcast to all masters
//   haddr/htrans/hwrite/hsize/hwdata      bus address/data phase outputs
//   hrdata, hready, hresp      bus returns from the slave mux
//   hmaster, hmaster_vld       registered data-phase owner and valid
// -----------------------------------------------------------------------------
module ahb_master_arbiter
    import ahb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_haddr,
    input  logic [N_MASTERS*2-1:0]        m_htrans,
    input  logic [N_MASTERS-1:0]          m_hwrite,
    input  logic [N_MASTERS*3-1:0]        m_hsize,
    input  logic [N_MASTERS*DATA_W-1:0]   m_hwdata,
    output logic [N_MASTERS-1:0]          m_hready,
    output logic [N_MASTERS-1:0]          m_hresp,
    output logic [DATA_W-1:0]             m_hrdata,
    output logic [ADDR_W-1:0]             haddr,
    output logic [1:0]                    htrans,
    output logic                          hwrite,
    output logic [2:0]                    hsize,
    output logic [DATA_W-1:0]             hwdata,
    input  logic [DATA_W-1:0]             hrdata,
    input  logic                          hready,
    input  logic                          hresp,
    output logic [1:0]                    hmaster,
    output logic                          hmaster_vld
);

    logic [N_MASTERS-1:0]   req;
    logic [MAX_MASTERS-1:0] req_pad;
    mst_idx_t               data_owner_q, data_owner_d;
    logic                   data_vld_q, data_vld_d;
    mst_idx_t               pick_idx, addr_owner;
    logic                   pick_any, sticky, addr_req;
    logic [1:0]             owner_trans;

`ifdef ARB_ROUND_ROBIN_EN
    mst_idx_t               rr_ptr_q, rr_ptr_d;
`endif

    // HTRANS[1] set means NONSEQ or SEQ; BUSY counts as idle.
    always_comb begin : req_c
        req = '0;
        for (int m = 0; m < N_MASTERS; m++) begin
            req[m] = m_htrans[2*m+1];
        end
    end

    arb_pick #(
        .N_MASTERS (N_MASTERS)
    ) u_pick (
        .req_i    (req),
`ifdef ARB_ROUND_ROBIN_EN
        .rr_ptr_i (rr_ptr_q),
`endif
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    // The current data-phase owner keeps the bus while it keeps requesting,
    // so a burst is never split. With hready=0 nothing here changes, which
    // freezes the grant for the whole wait state.
    always_comb begin : grant_c
        req_pad                = '0;
        req_pad[N_MASTERS-1:0] = req;
        sticky                 = data_vld_q & req_pad[data_owner_q];
        addr_owner             = sticky ? data_owner_q : pick_idx;
        addr_req               = sticky | pick_any;
    end

    always_comb begin : bus_mux_c
        haddr       = '0;
        hwrite      = 1'b0;
        hsize       = '0;
        owner_trans = HTRANS_IDLE;
        hwdata      = '0;
        for (int m = 0; m < N_MASTERS; m++) begin
            if (addr_owner == mst_idx_t'(m)) begin
                haddr       = m_haddr[m*ADDR_W +: ADDR_W];
                hwrite      = m_hwrite[m];
                hsize       = m_hsize[m*3 +: 3];
                owner_trans = m_htrans[m*2 +: 2];
            end
            if (data_vld_q && data_owner_q == mst_idx_t'(m)) begin
                hwdata = m_hwdata[m*DATA_W +: DATA_W];
            end
        end
        htrans = (reset && addr_req) ? owner_trans : HTRANS_IDLE;
    end

    // Losers that are requesting see hready low and hold their address.
    always_comb begin : master_resp_c
        m_hready = '0;
        m_hresp  = '0;
        for (int m = 0; m < N_MASTERS; m++) begin
            if (!reset) begin
                m_hready[m] = 1'b1;
            end else if (addr_owner == mst_idx_t'(m) ||
                         (data_vld_q && data_owner_q == mst_idx_t'(m))) begin
                m_hready[m] = hready;
            end else begin
                m_hready[m] = ~req[m];
            end
            if (data_vld_q && data_owner_q == mst_idx_t'(m)) begin
                m_hresp[m] = hresp;
            end else begin
                m_hresp[m] = HRESP_OKAY;
            end
        end
    end

    assign m_hrdata    = hrdata;
    assign hmaster     = data_owner_q;
    assign hmaster_vld = data_vld_q;

    always_comb begin : next_c
        data_owner_d = data_owner_q;
        data_vld_d   = data_vld_q;
        if (hready) begin
            data_owner_d = addr_owner;
            data_vld_d   = addr_req;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Only a fresh (non-sticky) accepted grant moves the search start.
    always_comb begin : rr_next_c
        rr_ptr_d = rr_ptr_q;
        if (hready && addr_req && !sticky) begin
            if (addr_owner == mst_idx_t'(N_MASTERS - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = addr_owner + mst_idx_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin : rr_q_ff
        if (!reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin : state_ff
        if (!reset) begin
            data_owner_q <= '0;
            data_vld_q   <= 1'b0;
        end else begin
            data_owner_q <= data_owner_d;
            data_vld_q   <= data_vld_d;
        end
    end

endmodule : ahb_master_arbiter

// File: tb/tb_ahb_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ahb_master_arbiter
// Self-checking bench for ahb_master_arbiter (2 masters, 32-bit bus).
// A reference model predicts the full output vector every cycle; the monitor
// pops and compares at the falling edge. Directed spot checks cover the
// single-master, contention, wait-state, burst, error and reset scenarios.
// -----------------------------------------------------------------------------
module tb_ahb_master_arbiter;
    import ahb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int W  = AW + 2 + 1 + 3 + DW + N + N + DW + 2 + 1;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic              clk;
    logic              reset;
    logic [N*AW-1:0]   m_haddr;
    logic [N*2-1:0]    m_htrans;
    logic [N-1:0]      m_hwrite;
    logic [N*3-1:0]    m_hsize;
    logic [N*DW-1:0]   m_hwdata;
    logic [N-1:0]      m_hready;
    logic [N-1:0]      m_hresp;
    logic [DW-1:0]     m_hrdata;
    logic [AW-1:0]     haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [DW-1:0]     hwdata;
    logic [DW-1:0]     hrdata;
    logic              hready;
    logic              hresp;
    logic [1:0]        hmaster;
    logic              hmaster_vld;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ahb_master_arbiter #(
        .N_MASTERS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m_haddr     (m_haddr),
        .m_htrans    (m_htrans),
        .m_hwrite    (m_hwrite),
        .m_hsize     (m_hsize),
        .m_hwdata    (m_hwdata),
        .m_hready    (m_hready),
        .m_hresp     (m_hresp),
        .m_hrdata    (m_hrdata),
        .haddr       (haddr),
        .htrans      (htrans),
        .hwrite      (hwrite),
        .hsize       (hsize),
        .hwdata      (hwdata),
        .hrdata      (hrdata),
        .hready      (hready),
        .hresp       (hresp),
        .hmaster     (hmaster),
        .hmaster_vld (hmaster_vld)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    // Reference model state: who owns the data phase, and where the
    // round-robin search would start.
    int mdl_own = 0;
    bit mdl_vld = 0;
    int mdl_rr  = 0;
    int pend_g;
    bit pend_gv;
    bit pend_st;

    // Reference model: grant rules evaluated directly on the request list.
    task automatic model_eval(output logic [W-1:0] e, output int g,
                              output bit gv, output bit st);
        int own, rr, start, c;
        bit vld;
        bit req[N];
        logic [N-1:0] e_rdy, e_resp;
        logic [1:0]   e_trans;
        logic [DW-1:0] e_wdata;
        own = reset ? mdl_own : 0;
        vld = reset ? mdl_vld : 1'b0;
        rr  = reset ? mdl_rr  : 0;
        for (int m = 0; m < N; m++) req[m] = m_htrans[2*m+1];
        st = vld && req[own];
        g  = 0;
        gv = 1'b0;
        if (st) begin
            g  = own;
            gv = 1'b1;
        end else begin
            start = RR_MODE ? rr : 0;
            for (int k = 0; k < N; k++) begin
                c = (start + k) % N;
                if (!gv && req[c]) begin
                    g  = c;
                    gv = 1'b1;
                end
            end
        end
        e_trans = (reset && gv) ? m_htrans[g*2 +: 2] : 2'b00;
        e_wdata = vld ? m_hwdata[own*DW +: DW] : '0;
        for (int m = 0; m < N; m++) begin
            if (!reset) e_rdy[m] = 1'b1;
            else if (m == g || (vld && m == own)) e_rdy[m] = hready;
            else e_rdy[m] = !req[m];
            e_resp[m] = (vld && m == own) ? hresp : 1'b0;
        end
        e = {m_haddr[g*AW +: AW], e_trans, m_hwrite[g], m_hsize[g*3 +: 3],
             e_wdata, e_rdy, e_resp, hrdata, 2'(own), vld};
    endtask

    // ---------------- driver tasks ----------------
    // Called at posedge+1 after inputs are set: predict and queue.
    task automatic step_begin(input string tag);
        logic [W-1:0] e;
        model_eval(e, pend_g, pend_gv, pend_st);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #2;
    endtask

    // Advance the model across the next rising edge; returns at posedge+1.
    task automatic step_end();
        @(posedge clk);
        if (!reset) begin
            mdl_own = 0;
            mdl_vld = 1'b0;
            mdl_rr  = 0;
        end else if (hready) begin
            mdl_own = pend_g;
            mdl_vld = pend_gv;
            if (RR_MODE && pend_gv && !pend_st) mdl_rr = (pend_g + 1) % N;
        end
        #1;
    endtask

    task automatic step(input string tag);
        step_begin(tag);
        step_end();
    endtask

    task automatic set_m(input int m, input logic [1:0] tr,
                         input logic [31:0] a, input logic w,
                         input logic [31:0] wd);
        m_htrans[2*m +: 2] = tr;
        m_haddr[m*AW +: AW] = a;
        m_hwrite[m] = w;
        m_hsize[3*m +: 3] = HSIZE_WORD;
        m_hwdata[m*DW +: DW] = wd;
    endtask

    task automatic spot(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step("rst");
        reset = 1'b1;
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [W-1:0] e, a;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = {haddr, htrans, hwrite, hsize, hwdata, m_hready, m_hresp,
                     m_hrdata, hmaster, hmaster_vld};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL scb[%s] t=%0t actual=%h expected=%h", t, $time, a, e);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int win, lose;
    logic [31:0] addr_of[N];

    initial begin : stim
        reset = 1'b0;
        m_haddr = '0; m_htrans = '0; m_hwrite = '0; m_hsize = '0; m_hwdata = '0;
        hrdata = '0; hready = 1'b1; hresp = 1'b0;
        @(posedge clk); #1;

        // Reset state: a pending request must not reach the bus.
        set_m(0, HTRANS_NONSEQ, 32'h0000_0100, 1'b0, 32'h0);
        step_begin("reset");
        spot("rst_vld", 64'(hmaster_vld), 64'd0);
        spot("rst_htrans", 64'(htrans), 64'd0);
        spot("rst_hready", 64'(m_hready), 64'b11);
        spot("rst_hmaster", 64'(hmaster), 64'd0);
        step_end();

        // Contention on an idle bus: master 0 wins, master 1 stalls.
        reset = 1'b1;
        set_m(0, HTRANS_NONSEQ, 32'h1000_0000, 1'b0, 32'h0);
        set_m(1, HTRANS_NONSEQ, 32'h2000_0000, 1'b0, 32'h0);
        step_begin("cont_a");
        spot("cont_a_haddr", 64'(haddr), 64'h1000_0000);
        spot("cont_a_hready", 64'(m_hready), 64'b01);
        step_end();
        set_m(0, HTRANS_IDLE, 32'h1000_0000, 1'b0, 32'h0);
        step_begin("cont_b");
        spot("cont_b_haddr", 64'(haddr), 64'h2000_0000);
        spot("cont_b_htrans", 64'(htrans), 64'(HTRANS_NONSEQ));
        spot("cont_b_hready1", 64'(m_hready[1]), 64'd1);
        step_end();
        set_m(1, HTRANS_IDLE, 32'h2000_0000, 1'b0, 32'h0);
        step("cont_c");

        // Single master read.
        set_m(0, HTRANS_NONSEQ, 32'h0000_0100, 1'b0, 32'h0);
        step_begin("single_a");
        spot("single_htrans", 64'(htrans), 64'(HTRANS_NONSEQ));
        spot("single_haddr", 64'(haddr), 64'h100);
        step_end();
        set_m(0, HTRANS_IDLE, 32'h0000_0100, 1'b0, 32'h0);
        hrdata = 32'hA5A5_0001;
        step_begin("single_d");
        spot("single_hmaster", 64'(hmaster), 64'd0);
        spot("single_vld", 64'(hmaster_vld), 64'd1);
        spot("single_hrdata", 64'(m_hrdata), 64'hA5A5_0001);
        step_end();

        // Second contention: round-robin now favours master 1.
        addr_of[0] = 32'h1000_0000;
        addr_of[1] = 32'h2000_0000;
        win  = RR_MODE ? 1 : 0;
        lose = 1 - win;
        set_m(0, HTRANS_NONSEQ, addr_of[0], 1'b0, 32'h0);
        set_m(1, HTRANS_NONSEQ, addr_of[1], 1'b0, 32'h0);
        step_begin("cont2_a");
        spot("cont2_haddr", 64'(haddr), 64'(addr_of[win]));
        spot("cont2_loser_hready", 64'(m_hready[lose]), 64'd0);
        step_end();
        set_m(win, HTRANS_IDLE, addr_of[win], 1'b0, 32'h0);
        step_begin("cont2_b");
        spot("cont2_b_haddr", 64'(haddr), 64'(addr_of[lose]));
        step_end();

        // Asynchronous reset in the middle of a data phase.
        set_m(0, HTRANS_NONSEQ, 32'h3000_0000, 1'b0, 32'h0);
        set_m(1, HTRANS_IDLE, 32'h2000_0000, 1'b0, 32'h0);
        step_begin("pre_areset");
        #3;
        reset = 1'b0;
        mdl_own = 0; mdl_vld = 1'b0; mdl_rr = 0;
        #1;
        spot("areset_vld", 64'(hmaster_vld), 64'd0);
        spot("areset_htrans", 64'(htrans), 64'd0);
        spot("areset_hready", 64'(m_hready), 64'b11);
        step_end();
        reset = 1'b1;
        set_m(0, HTRANS_IDLE, 32'h3000_0000, 1'b0, 32'h0);
        set_m(1, HTRANS_NONSEQ, 32'h2000_0040, 1'b0, 32'h0);
        step_begin("rst_rel");
        spot("rel_htrans", 64'(htrans), 64'(HTRANS_NONSEQ));
        spot("rel_haddr", 64'(haddr), 64'h2000_0040);
        spot("rel_hready1", 64'(m_hready[1]), 64'd1);
        step_end();
        set_m(1, HTRANS_IDLE, 32'h2000_0040, 1'b0, 32'h0);
        step("idle0");

        // Wait states during a master 0 write; master 1 stays stalled.
        set_m(0, HTRANS_NONSEQ, 32'h0000_0040, 1'b1, 32'h0);
        set_m(1, HTRANS_NONSEQ, 32'h2000_0080, 1'b0, 32'h0);
        step_begin("wait_a");
        spot("wait_a_haddr", 64'(haddr), 64'h40);
        spot("wait_a_hwrite", 64'(hwrite), 64'd1);
        step_end();
        set_m(0, HTRANS_NONSEQ, 32'h0000_0044, 1'b1, 32'hDEAD_BEEF);
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_begin("wait_ws");
            spot("ws_hwdata", 64'(hwdata), 64'hDEAD_BEEF);
            spot("ws_haddr", 64'(haddr), 64'h44);
            spot("ws_hready", 64'(m_hready), 64'b00);
            step_end();
        end
        hready = 1'b1;
        step_begin("wait_go");
        spot("go_hwdata", 64'(hwdata), 64'hDEAD_BEEF);
        spot("go_hready", 64'(m_hready), 64'b01);
        step_end();
        set_m(0, HTRANS_IDLE, 32'h0000_0044, 1'b1, 32'h1234_5678);
        step_begin("wait_sw");
        spot("sw_haddr", 64'(haddr), 64'h2000_0080);
        spot("sw_hwdata", 64'(hwdata), 64'h1234_5678);
        step_end();
        set_m(1, HTRANS_IDLE, 32'h2000_0080, 1'b0, 32'h0);
        step("idle1");
        step("idle2");

        // Sticky burst: four back-to-back master 0 transfers before master 1.
        set_m(1, HTRANS_NONSEQ, 32'h2000_00C0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            set_m(0, HTRANS_NONSEQ, 32'h80 + 32'(4*i), 1'b0, 32'h0);
            step_begin("burst");
            spot("burst_haddr", 64'(haddr), 64'h80 + 64'(4*i));
            spot("burst_m1_stall", 64'(m_hready[1]), 64'd0);
            step_end();
        end
        set_m(0, HTRANS_IDLE, 32'h8C, 1'b0, 32'h0);
        step_begin("burst_end");
        spot("bend_haddr", 64'(haddr), 64'h2000_00C0);
        spot("bend_htrans", 64'(htrans), 64'(HTRANS_NONSEQ));
        step_end();

        // Two-cycle ERROR response on the master 1 data phase.
        set_m(1, HTRANS_IDLE, 32'h2000_00C0, 1'b0, 32'h0);
        hresp = 1'b1; hready = 1'b0;
        step_begin("err1");
        spot("err1_hresp", 64'(m_hresp), 64'b10);
        step_end();
        hready = 1'b1;
        step_begin("err2");
        spot("err2_hresp", 64'(m_hresp), 64'b10);
        step_end();
        hresp = 1'b0;
        step("idle3");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            reset  = ($urandom_range(0, 49) != 0);
            hready = ($urandom_range(0, 3) != 0);
            hresp  = ($urandom_range(0, 9) == 0);
            hrdata = $urandom;
            for (int m = 0; m < N; m++) begin
                m_htrans[2*m +: 2]   = 2'($urandom_range(0, 3));
                m_haddr[m*AW +: AW]  = $urandom;
                m_hwrite[m]          = 1'($urandom_range(0, 1));
                m_hsize[3*m +: 3]    = 3'($urandom_range(0, 2));
                m_hwdata[m*DW +: DW] = $urandom;
            end
            step("rand");
        end

        reset = 1'b1;
        m_htrans = '0;
        hready = 1'b1;
        step("drain");
        @(negedge clk); #1;
        spot("scb_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ahb_master_arbiter
